cfg_word_unpacker: RTL and testbench

CFG_WORD_UNPACKER -- requirements
Module: cfg_word_unpacker

---
 rtl/cfg_word_unpacker.sv | 153 +++++++++++++++
 tb/tb_cfg_word_unpacker.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_word_unpacker.sv
// Configuration-word unpacker: pulls 32-bit words from the config FIFO and writes them out MSB byte first.
// Optional running word checksum is compiled in with `define CFG_CHECKSUM_EN.
module cfg_word_unpacker #(
    parameter int SPI_WIDTH  = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 13,
    parameter int CNT_WIDTH  = 20
) (
    input  logic                  clk_chip,
    input  logic                  reset_n_chip,
    input  logic                  start,
    input  logic [3:0]            start_type,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic                  config_ready,
    output logic                  config_paulse,
    output logic [3:0]            config_data,
    output logic                  rd_req,
    input  logic                  rd_valid,
    input  logic [SPI_WIDTH-1:0]  rd_data,
    output logic                  buf_wr_en,
    input  logic                  buf_wr_ready,
    output logic [ADDR_WIDTH-1:0] buf_wr_addr,
    output logic [BYTE_WIDTH-1:0] buf_wr_data,
    output logic [SPI_WIDTH-1:0]  checksum
);

    localparam int BPW    = SPI_WIDTH / BYTE_WIDTH;
    localparam int BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] PULSE  = 2'd1;
    localparam logic [1:0] ACTIVE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]           state;
    logic [CNT_WIDTH-1:0] size;
    logic [CNT_WIDTH-1:0] words_received;
    logic [CNT_WIDTH-1:0] words_done;
    logic [SPI_WIDTH-1:0] mem [2];
    logic                 rd_ptr;
    logic                 wr_ptr;
    logic [1:0]           occ;
    logic [BIDX_W-1:0]    byte_idx;
    logic [SPI_WIDTH-1:0] head_shift;

    logic active, legal, load, push, accept, word_end, last_byte;

    // Zero means the type is not a legal load.
    function automatic logic [CNT_WIDTH-1:0] type_size(input logic [3:0] t);
        case (t)
            4'd1, 4'd2: type_size = CNT_WIDTH'(2048);
            4'd3, 4'd4: type_size = CNT_WIDTH'(256);
            4'd5, 4'd6: type_size = CNT_WIDTH'(512);
            4'd7, 4'd8: type_size = CNT_WIDTH'(43);
            default:    type_size = '0;
        endcase
    endfunction

    always_comb begin
        active        = (state == ACTIVE);
        legal         = (type_size(start_type) != '0);
        load          = (state == IDLE) && start && legal;
        push          = active && rd_valid && (occ != 2'd2) && (words_received < size);
        buf_wr_en     = active && (occ != 2'd0);
        accept        = buf_wr_en && buf_wr_ready;
        word_end      = accept && (byte_idx == BIDX_W'(BPW - 1));
        last_byte     = word_end && (words_done == size - 1'b1);
        rd_req        = active && (occ == 2'd0) && !rd_valid && (words_received < size);
        config_paulse = (state == PULSE) && config_ready;
        busy          = (state != IDLE);
        done          = (state == DONE);
        head_shift    = mem[rd_ptr] << (BYTE_WIDTH * byte_idx);
        buf_wr_data   = head_shift[SPI_WIDTH-1 -: BYTE_WIDTH];
    end

    always_ff @(posedge clk_chip or negedge reset_n_chip) begin
        if (!reset_n_chip) begin
            state          <= IDLE;
            err            <= 1'b0;
            config_data    <= '0;
            size           <= '0;
            words_received <= '0;
            words_done     <= '0;
            mem[0]         <= '0;
            mem[1]         <= '0;
            rd_ptr         <= 1'b0;
            wr_ptr         <= 1'b0;
            occ            <= '0;
            byte_idx       <= '0;
            buf_wr_addr    <= '0;
        end else begin
            err <= (state == IDLE) && start && !legal;

            case (state)
                IDLE: if (load) begin
                    state          <= PULSE;
                    config_data    <= start_type;
                    size           <= type_size(start_type);
                    words_received <= '0;
                    words_done     <= '0;
                    rd_ptr         <= 1'b0;
                    wr_ptr         <= 1'b0;
                    occ            <= '0;
                    byte_idx       <= '0;
                    buf_wr_addr    <= '0;
                end
                PULSE:   if (config_ready) state <= ACTIVE;
                ACTIVE:  if (last_byte) state <= DONE;
                default: state <= IDLE;
            endcase

            if (push) begin
                mem[wr_ptr]    <= rd_data;
                wr_ptr         <= ~wr_ptr;
                words_received <= words_received + 1'b1;
            end

            if (accept) begin
                buf_wr_addr <= buf_wr_addr + 1'b1;
                byte_idx    <= word_end ? '0 : byte_idx + 1'b1;
            end

            // Head word leaves after its last byte; simultaneous push/pop keeps occupancy.
            if (word_end) begin
                rd_ptr     <= ~rd_ptr;
                words_done <= words_done + 1'b1;
            end

            case ({push, word_end})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

`ifdef CFG_CHECKSUM_EN
    always_ff @(posedge clk_chip or negedge reset_n_chip) begin
        if (!reset_n_chip) begin
            checksum <= '0;
        end else if (load) begin
            checksum <= '0;
        end else if (push) begin
            checksum <= checksum + rd_data;
        end
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_cfg_word_unpacker.sv
// Bench for cfg_word_unpacker: random loads against a scoreboard of expected byte writes.
// Expected checksum follows CFG_CHECKSUM_EN when the bench is built with that macro.
module tb_cfg_word_unpacker;

    logic        clk_chip = 1'b0;
    logic        reset_n_chip;
    logic        start;
    logic [3:0]  start_type;
    logic        busy, done, err;
    logic        config_ready;
    logic        config_paulse;
    logic [3:0]  config_data;
    logic        rd_req;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        buf_wr_en;
    logic        buf_wr_ready;
    logic [12:0] buf_wr_addr;
    logic [7:0]  buf_wr_data;
    logic [31:0] checksum;

    cfg_word_unpacker dut (
        .clk_chip(clk_chip), .reset_n_chip(reset_n_chip),
        .start(start), .start_type(start_type),
        .busy(busy), .done(done), .err(err),
        .config_ready(config_ready), .config_paulse(config_paulse), .config_data(config_data),
        .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
        .buf_wr_en(buf_wr_en), .buf_wr_ready(buf_wr_ready),
        .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
        .checksum(checksum)
    );

    always #5 clk_chip = ~clk_chip;

    typedef struct packed {
        logic [12:0] addr;
        logic [7:0]  data;
        logic        last;
        logic [31:0] sum;
    } item_t;

    item_t       sb_q[$];
    logic [3:0]  cfg_q[$];
    int          err_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          wr_cnt = 0;

    logic [31:0] words[$];
    int          widx;
    bit          take;
    bit          fifo_rand;
    int          rdy_mode;
    int          cr_hold;
    bit          exp_done;
    logic [31:0] exp_sum;

    always @(posedge clk_chip) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_size(input logic [3:0] t);
        if (t == 0 || t > 8) return 0;
        if (t <= 2) return 2048;
        if (t <= 4) return 256;
        if (t <= 6) return 512;
        return 43;
    endfunction

    // One clock: inputs change 1 time unit after the rising edge, the FIFO decides at the falling edge.
    task automatic cycle();
        @(posedge clk_chip);
        #1;
        start    = 1'b0;
        rd_valid = take;
        if (take && widx < words.size()) begin
            rd_data = words[widx];
            widx++;
        end else begin
            rd_data = $urandom;
        end
        case (rdy_mode)
            0:       buf_wr_ready = 1'b1;
            1:       buf_wr_ready = ~buf_wr_ready;
            default: buf_wr_ready = ($urandom % 4) != 0;
        endcase
        if (cr_hold > 0) begin
            config_ready = 1'b0;
            cr_hold--;
        end else begin
            config_ready = 1'b1;
        end
        @(negedge clk_chip);
        take = rd_req && (!fifo_rand || ($urandom % 3) != 0);
    endtask

    task automatic do_reset_check();
        reset_n_chip = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_config_paulse", config_paulse, 0);
        chk("rst_config_data", config_data, 0);
        chk("rst_rd_req", rd_req, 0);
        chk("rst_buf_wr_en", buf_wr_en, 0);
        chk("rst_buf_wr_addr", buf_wr_addr, 0);
        chk("rst_buf_wr_data", buf_wr_data, 0);
        chk("rst_checksum", checksum, 0);
        sb_q.delete();
        take     = 1'b0;
        rd_valid = 1'b0;
        repeat (3) cycle();
        @(posedge clk_chip);
        #1;
        reset_n_chip = 1'b1;
    endtask

    task automatic run_load(input logic [3:0] t, input bit seq_words, input int rmode,
                            input bit frand, input int hold, input int abort_after);
        int n;
        logic [31:0] sum;
        item_t it;
        n = model_size(t);
        if (n == 0) begin
            cycle();
            start = 1'b1;
            start_type = t;
            err_q.push_back(cyc + 1);
            repeat (4) begin
                cycle();
                chk("err_busy", busy, 0);
            end
            return;
        end
        words.delete();
        widx = 0;
        sum  = 0;
        for (int i = 0; i < n; i++) begin
            words.push_back(seq_words ? 32'(i + 1) : 32'($urandom));
            sum += words[i];
        end
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 4; b++) begin
                it.addr = 13'((4 * i + b) % 8192);
                it.data = 8'(words[i] >> (24 - 8 * b));
                it.last = (i == n - 1) && (b == 3);
`ifdef CFG_CHECKSUM_EN
                it.sum  = sum;
`else
                it.sum  = 32'd0;
`endif
                sb_q.push_back(it);
            end
        end
        cfg_q.push_back(t);
        rdy_mode  = rmode;
        fifo_rand = frand;
        cycle();
        cr_hold    = hold;
        start      = 1'b1;
        start_type = t;
        wr_cnt     = 0;
        cycle();
        chk("busy_after_start", busy, 1);
        for (int k = 0; k <= 40000; k++) begin
            if (k == 40000) begin
                n_cmp++;
                n_bad++;
                $display("FAIL load_timeout: type %0d, no done after %0d cycles", t, k);
                break;
            end
            cycle();
            if (abort_after > 0 && wr_cnt >= abort_after) begin
                do_reset_check();
                return;
            end
            if (done) break;
            if (k % 37 == 20) begin
                start      = 1'b1;
                start_type = 4'd1;
            end
        end
        cycle();
        chk("busy_after_done", busy, 0);
    endtask

    // Monitor: compares every presented output against the scoreboard queues.
    initial begin
        exp_done = 1'b0;
        exp_sum  = '0;
        forever begin
            @(negedge clk_chip);
            if (!reset_n_chip) begin
                exp_done = 1'b0;
                continue;
            end
            if (exp_done) begin
                chk("done_pulse", done, 1);
                chk("checksum", checksum, exp_sum);
                exp_done = 1'b0;
            end else if (done) begin
                chk("done_unexpected", done, 0);
            end
            if (buf_wr_en && buf_wr_ready) begin
                wr_cnt++;
                if (sb_q.size() == 0) begin
                    chk("write_unexpected", {19'd0, buf_wr_addr}, 32'hffffffff);
                end else begin
                    item_t it;
                    it = sb_q.pop_front();
                    chk("wr_addr", buf_wr_addr, it.addr);
                    chk("wr_data", buf_wr_data, it.data);
                    if (it.last) begin
                        exp_done = 1'b1;
                        exp_sum  = it.sum;
                    end
                end
            end
            if (config_paulse) begin
                chk("paulse_ready", config_ready, 1);
                if (cfg_q.size() == 0) chk("paulse_unexpected", config_paulse, 0);
                else chk("config_data", config_data, cfg_q.pop_front());
            end
            if (err) begin
                if (err_q.size() == 0) chk("err_unexpected", err, 0);
                else chk("err_cycle", cyc, err_q.pop_front());
            end
        end
    end

    initial begin
        reset_n_chip = 1'b0;
        start        = 1'b0;
        start_type   = 4'd0;
        config_ready = 1'b0;
        rd_valid     = 1'b0;
        rd_data      = '0;
        buf_wr_ready = 1'b0;
        take         = 1'b0;
        fifo_rand    = 1'b0;
        rdy_mode     = 0;
        cr_hold      = 0;
        widx         = 0;
        repeat (2) @(negedge clk_chip);
        do_reset_check();

        run_load(4'd7, 1'b1, 0, 1'b0, 0, 0);
        run_load(4'd0, 1'b0, 0, 1'b0, 0, 0);
        run_load(4'd9, 1'b0, 0, 1'b0, 0, 0);
        run_load(4'd15, 1'b0, 0, 1'b0, 0, 0);
        run_load(4'd3, 1'b0, 1, 1'b0, 0, 0);
        run_load(4'd8, 1'b0, 2, 1'b1, 10, 0);
        run_load(4'd5, 1'b0, 2, 1'b1, 0, 100);
        run_load(4'd5, 1'b0, 2, 1'b1, 0, 0);
        run_load(4'd1, 1'b0, 0, 1'b0, 0, 0);
        for (int r = 0; r < 4; r++) begin
            logic [3:0] t;
            t = 4'($urandom_range(3, 8));
            run_load(t, 1'b0, 2, 1'b1, $urandom_range(0, 5), 0);
        end
        run_load(4'd2, 1'b0, 2, 1'b1, 2, 0);

        repeat (3) cycle();
        chk("sb_drained", sb_q.size(), 0);
        chk("cfg_drained", cfg_q.size(), 0);
        chk("err_drained", err_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
